// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states, register
// offsets (dev_addr[3:2]), CTRL bit positions and MODE encodings.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_PRESC  = 2'd3;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [CTRL_W-1:0] CTRL_RESET = {1'b0, MODE_ONESHOT, 1'b0};

    // Only MODE=01 reloads; both 1x encodings fall back to one-shot.
    function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MODE_LSB +: 2] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: pulses tick_o once every presc_i+1 enabled cycles; held at zero while clear_i.
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    // >= keeps the divider sane if PRESC is lowered below the running count.
    assign tick_o = !clear_i && (cnt_q >= presc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT/PRESC) with level irq.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       dev_addr,
    input  logic [3:0]        dev_byteen,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              irq
);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   preset_q, preset_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic                flag_q, flag_d;
    logic [DATA_W-1:0]   wmask;
    logic [DATA_W-1:0]   presc_rd;
    logic                tick;
    logic                wr_en;
    logic                ctrl_wr;
    logic                preset_wr;
    logic [1:0]          reg_sel;
    logic                unused_addr;

    assign reg_sel     = dev_addr[3:2];
    assign wr_en       = |dev_byteen;
    assign ctrl_wr     = wr_en && (reg_sel == REG_CTRL);
    assign preset_wr   = wr_en && (reg_sel == REG_PRESET);
    assign unused_addr = ^{dev_addr[31:4], dev_addr[1:0]};

    // Byte-lane write mask; one byte enable per 8 data bits.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{dev_byteen[gi]}};
        end
    endgenerate

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DATA_W-1:0]  presc_merged;

    assign presc_merged = (DATA_W'(presc_q) & ~wmask) | (dev_wdata & wmask);
    assign presc_rd     = DATA_W'(presc_q);

    always_comb begin
        presc_d = presc_q;
        if (wr_en && (reg_sel == REG_PRESC)) begin
            presc_d = presc_merged[PRESC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != ST_CNT),
        .presc_i (presc_q),
        .tick_o  (tick)
    );
`else
    localparam int UNUSED_PRESC_W = PRESC_W;
    assign presc_rd = '0;
    assign tick     = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q > DATA_W'(1)) begin
                        count_d = count_q - DATA_W'(1);
                    end else begin
                        count_d = '0;
                        flag_d  = 1'b1;
                        state_d = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_q)) begin
                    flag_d  = 1'b0;
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software stores are applied last so they win over the FSM's EN clear.
        if (ctrl_wr) begin
            flag_d = 1'b0;
            if (dev_byteen[0]) begin
                ctrl_d = dev_wdata[CTRL_W-1:0];
            end
        end
        if (preset_wr) begin
            preset_d = (preset_q & ~wmask) | (dev_wdata & wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= CTRL_RESET;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    assign irq = ctrl_q[CTRL_IM] & flag_q;

    always_comb begin
        dev_rdata = '0;
        case (reg_sel)
            REG_CTRL:   dev_rdata = DATA_W'(ctrl_q);
            REG_PRESET: dev_rdata = preset_q;
            REG_COUNT:  dev_rdata = count_q;
            REG_PRESC:  dev_rdata = presc_rd;
            default:    dev_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized runs checked
// against closed-form expectations (load two edges after enable, expiry P*D cycles later).
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] dev_addr;
    logic [3:0]  dev_byteen;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    timer_counter #(
        .DATA_W  (32),
        .PRESC_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dev_addr   (dev_addr),
        .dev_byteen (dev_byteen),
        .dev_wdata  (dev_wdata),
        .dev_rdata  (dev_rdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [3:0] be, input logic [31:0] data);
        dev_addr   = {28'h0, off};
        dev_byteen = be;
        dev_wdata  = data;
        step();
        dev_byteen = 4'h0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] data);
        dev_addr = {28'h0, off};
        #1;
        data = dev_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Expected view k edges after the enabling CTRL write (edge 0), from idle.
    function automatic void model_at(input int k, input int p, input int d, input bit reload,
                                     input int prev, output int cnt, output bit fire,
                                     output bit en_on);
        int pe;
        int run;
        int j;
        pe  = (p == 0) ? 1 : p;
        run = pe * d;
        cnt = prev; fire = 1'b0; en_on = 1'b1;
        if (k >= 2) begin
            if (!reload) begin
                cnt   = (k - 2 < run) ? p - (k - 2) / d : 0;
                fire  = (k >= run + 2);
                en_on = (k < run + 3);
            end else begin
                j    = (k - 2) % (run + 2);
                cnt  = (j < run) ? p - j / d : 0;
                fire = (j == run);
            end
        end
    endfunction

    task automatic run_check(input string tag, input int p, input int d, input bit reload,
                             input logic [3:0] ctrl_val, input int prev, input int k0, input int k1);
        int          cnt;
        bit          fire;
        bit          en_on;
        logic [31:0] v;
        for (int k = k0; k <= k1; k++) begin
            step();
            model_at(k, p, d, reload, prev, cnt, fire, en_on);
            rd(4'h8, v);
            chk($sformatf("%s_count_k%0d", tag, k), v, 32'(cnt));
            rd(4'h0, v);
            chk($sformatf("%s_ctrl_k%0d", tag, k), v, {28'h0, ctrl_val[3:1], en_on});
            chk($sformatf("%s_irq_k%0d", tag, k), {31'h0, irq}, {31'h0, fire & ctrl_val[3]});
            $display("[TB] %s k=%0d count=%0d irq=%0b", tag, k, cnt, fire & ctrl_val[3]);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] pmodel;
        logic [3:0]  be;
        logic [31:0] data;
        logic [3:0]  cval;
        int          p;
        int          mode;
        int          im;
        int          pe;

        reset      = 1'b0;
        dev_addr   = 32'h0;
        dev_byteen = 4'h0;
        dev_wdata  = 32'h0;

        // 1: reset state
        do_reset();
        rd(4'h0, v); chk("rst_ctrl", v, 32'h0);
        rd(4'h4, v); chk("rst_preset", v, 32'h0);
        rd(4'h8, v); chk("rst_count", v, 32'h0);
        rd(4'hC, v); chk("rst_presc", v, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);

        // 2: one-shot PRESET=5, irq after edge 7, cleared by CTRL write
        wr(4'h4, 4'hF, 32'd5);
        wr(4'h0, 4'hF, 32'h9);
        run_check("oneshot5", 5, 1, 1'b0, 4'h9, 0, 1, 10);
        wr(4'h0, 4'hF, 32'h0);
        chk("oneshot5_irq_clr", {31'h0, irq}, 32'h0);
        rd(4'h8, v); chk("oneshot5_count_final", v, 32'h0);

        // 3: auto-reload PRESET=3, pulse every 5 cycles
        do_reset();
        wr(4'h4, 4'hF, 32'd3);
        wr(4'h0, 4'hF, 32'hB);
        run_check("reload3", 3, 1, 1'b1, 4'hB, 0, 1, 17);

        // 4: byte-lane merges, read-only COUNT, CTRL upper bits, unused/prescaler slot
        do_reset();
        wr(4'h4, 4'hF, 32'hAABBCCDD);
        wr(4'h4, 4'h1, 32'h12345678);
        rd(4'h4, v); chk("merge_b0", v, 32'hAABBCC78);
        pmodel = 32'hAABBCC78;
        for (int i = 0; i < 6; i++) begin
            be   = 4'($urandom_range(0, 15));
            data = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) pmodel[8*b +: 8] = data[8*b +: 8];
            end
            wr(4'h4, be, data);
            rd(4'h4, v); chk($sformatf("merge_rand%0d_be%h", i, be), v, pmodel);
        end
        wr(4'h8, 4'hF, 32'hFFFFFFFF);
        rd(4'h8, v); chk("count_ro", v, 32'h0);
        wr(4'h0, 4'hF, 32'hFFFFFFF6);
        rd(4'h0, v); chk("ctrl_upper_zero", v, 32'h6);
        wr(4'hC, 4'hF, 32'hDEAD0005);
`ifdef TIMER_PRESCALER_EN
        rd(4'hC, v); chk("presc_rw", v, 32'h00000005);
`else
        rd(4'hC, v); chk("presc_absent", v, 32'h0);
`endif

        // 5: IM=0 expiry keeps irq low; setting IM afterwards clears the flag
        do_reset();
        p = int'($urandom_range(1, 6));
        wr(4'h4, 4'hF, 32'(p));
        wr(4'h0, 4'hF, 32'h1);
        run_check("im0", p, 1, 1'b0, 4'h1, 0, 1, p + 4);
        wr(4'h0, 4'hF, 32'h8);
        chk("im0_irq_after_im", {31'h0, irq}, 32'h0);
        step();
        chk("im0_irq_later", {31'h0, irq}, 32'h0);

        // 6: EN cleared mid-count freezes COUNT at 2; re-enable reloads; reset in INT
        do_reset();
        wr(4'h4, 4'hF, 32'd6);
        wr(4'h0, 4'hF, 32'h9);
        run_check("stop", 6, 1, 1'b0, 4'h9, 0, 1, 5);
        wr(4'h0, 4'hF, 32'h8);
        for (int i = 0; i < 4; i++) begin
            rd(4'h8, v); chk($sformatf("frozen_count%0d", i), v, 32'd2);
            chk($sformatf("frozen_irq%0d", i), {31'h0, irq}, 32'h0);
            step();
        end
        wr(4'h0, 4'hF, 32'h9);
        run_check("reen", 6, 1, 1'b0, 4'h9, 2, 1, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(4'h0, v); chk("intrst_ctrl", v, 32'h0);
        rd(4'h4, v); chk("intrst_preset", v, 32'h0);
        rd(4'h8, v); chk("intrst_count", v, 32'h0);
        chk("intrst_irq", {31'h0, irq}, 32'h0);

        // PRESET written during CNT only takes effect at the next load
        wr(4'h4, 4'hF, 32'd4);
        wr(4'h0, 4'hF, 32'h9);
        run_check("pre_mid", 4, 1, 1'b0, 4'h9, 0, 1, 3);
        wr(4'h4, 4'hF, 32'd9);
        rd(4'h8, v); chk("pre_mid_count_k4", v, 32'd2);
        run_check("pre_mid", 4, 1, 1'b0, 4'h9, 0, 5, 8);
        wr(4'h0, 4'hF, 32'h9);
        run_check("pre_next", 9, 1, 1'b0, 4'h9, 0, 1, 3);

        // CTRL write on the INT edge overrides the one-shot EN clear
        do_reset();
        wr(4'h4, 4'hF, 32'd2);
        wr(4'h0, 4'hF, 32'h9);
        run_check("race", 2, 1, 1'b0, 4'h9, 0, 1, 4);
        wr(4'h0, 4'hF, 32'h9);
        rd(4'h0, v); chk("race_en_kept", v, 32'h9);
        chk("race_irq_clr", {31'h0, irq}, 32'h0);
        run_check("race_rerun", 2, 1, 1'b0, 4'h9, 0, 1, 5);

        // Randomized runs, including PRESET=0 and MODE=1x
        for (int it = 0; it < 8; it++) begin
            do_reset();
            p    = int'($urandom_range(0, 9));
            mode = int'($urandom_range(0, 3));
            im   = int'($urandom_range(0, 1));
            pe   = (p == 0) ? 1 : p;
            cval = {im[0], mode[1:0], 1'b1};
            wr(4'h4, 4'hF, 32'(p));
            wr(4'h0, 4'hF, {28'h0, cval});
            run_check($sformatf("rnd%0d_p%0d_m%0d", it, p, mode), p, 1, mode == 1, cval, 0, 1,
                      (mode == 1) ? 3 * (pe + 2) + 1 : pe + 5);
        end

`ifdef TIMER_PRESCALER_EN
        // Prescaler: PRESC=1, PRESET=2 -> irq six cycles after enable
        do_reset();
        wr(4'hC, 4'hF, 32'd1);
        wr(4'h4, 4'hF, 32'd2);
        wr(4'h0, 4'hF, 32'h9);
        run_check("presc_os", 2, 2, 1'b0, 4'h9, 0, 1, 8);
        do_reset();
        wr(4'hC, 4'hF, 32'd2);
        wr(4'h4, 4'hF, 32'd3);
        wr(4'h0, 4'hF, 32'hB);
        run_check("presc_rl", 3, 3, 1'b1, 4'hB, 0, 1, 26);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
